// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the DVP frame transmitter: FSM state encoding,
// line-length arithmetic and the byte-phase meaning of hcnt[0].
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  localparam logic BYTE_HI = 1'b0;
  localparam logic BYTE_LO = 1'b1;

  function automatic int line_len(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_timing_cnt.sv
// Byte-slot (hcnt) and line-period (vcnt) counters, advancing once per enabled tick.
// o_eol flags the last slot of a line; o_eos the last slot of the current state's last line.
module dvp_timing_cnt
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int H_W      = 10,
  parameter int V_W      = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic [V_W-1:0] i_lines,
  output logic [H_W-1:0] o_hcnt,
  output logic           o_eol,
  output logic           o_eos
);

  localparam logic [H_W-1:0] H_LAST = H_W'(line_len(H_ACTIVE, H_BLANK) - 1);

  logic [H_W-1:0] r_hcnt;
  logic [V_W-1:0] r_vcnt;

  assign o_hcnt = r_hcnt;
  assign o_eol  = (r_hcnt == H_LAST);
  assign o_eos  = o_eol && (r_vcnt == (i_lines - V_W'(1)));

  // Both counters come back to zero at the end of every state, so a new state starts at slot 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_en) begin
      if (o_eol) begin
        r_hcnt <= '0;
        r_vcnt <= o_eos ? '0 : r_vcnt + V_W'(1);
      end else begin
        r_hcnt <= r_hcnt + H_W'(1);
      end
    end
  end

endmodule

// File: rtl/dvp_frame_tx.sv
// Camera-side DVP transmitter: plays an RGB565 frame RAM out as vsync/href/p_data with sensor timing.
// Levels track the slot being presented; mem_rd/p_valid/frame_done are tick-qualified strobes; no backpressure.
module dvp_frame_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 17,
  parameter int V_FP        = 10,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              continuous,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        p_data,
  output logic              p_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int L_LEN = line_len(H_ACTIVE, H_BLANK);
  localparam int H_W   = $clog2(L_LEN);
  localparam int V_W   = $clog2(max4(VSYNC_LINES, V_BP, V_ACTIVE, V_FP) + 1);
  localparam logic [H_W-1:0] H_BYTES     = H_W'(2 * H_ACTIVE);
  localparam logic [H_W-1:0] H_LAST_BYTE = H_W'(2 * H_ACTIVE - 1);
  // Line 0 is prefetched in the last pre-active slot, so VSYNC_LINES + V_BP must be at least 1.
  localparam state_t S_FIRST      = (VSYNC_LINES > 0) ? S_VSYNC : S_VBP;
  localparam state_t S_POST_VSYNC = (V_BP > 0) ? S_VBP : S_ACTIVE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [H_W-1:0]    w_hcnt;
  logic              w_eol;
  logic              w_eos;
  logic [V_W-1:0]    w_lines;
  logic              w_cnt_en;
  logic              w_in_line;
  logic              w_frame_end;
  logic              w_rd_pixel;
  logic              w_rd_line;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_lo;

  dvp_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cnt_en),
    .i_lines (w_lines),
    .o_hcnt  (w_hcnt),
    .o_eol   (w_eol),
    .o_eos   (w_eos)
  );

  always_comb begin
    w_lines = '0;
    case (r_state)
      S_VSYNC:  w_lines = V_W'(VSYNC_LINES);
      S_VBP:    w_lines = V_W'(V_BP);
      S_ACTIVE: w_lines = V_W'(V_ACTIVE);
      S_VFP:    w_lines = V_W'(V_FP);
      default:  w_lines = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    w_rd_line   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FIRST;
      end
      S_VSYNC: begin
        if (tick && w_eos) w_state_nxt = S_POST_VSYNC;
      end
      S_VBP: begin
        if (tick && w_eos) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (tick && w_eos) begin
          if (V_FP > 0) begin
            w_state_nxt = S_VFP;
          end else begin
            w_frame_end = 1'b1;
            w_state_nxt = continuous ? S_FIRST : S_IDLE;
          end
        end
      end
      S_VFP: begin
        if (tick && w_eos) begin
          w_frame_end = 1'b1;
          w_state_nxt = continuous ? S_FIRST : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Pixel 0 of the next active line is fetched in the last slot of the line before it.
    w_rd_line = w_eol && (((r_state == S_ACTIVE) && !w_eos) ||
                          ((r_state != S_ACTIVE) && w_eos && (w_state_nxt == S_ACTIVE)));
  end

  assign w_cnt_en   = tick && (r_state != S_IDLE);
  assign w_in_line  = (r_state == S_ACTIVE) && (w_hcnt < H_BYTES);
  assign w_rd_pixel = w_in_line && (w_hcnt[0] == BYTE_LO) && (w_hcnt != H_LAST_BYTE);

  assign mem_rd     = tick && (w_rd_pixel || w_rd_line);
  assign mem_addr   = r_addr;
  assign vsync      = (r_state == S_VSYNC);
  assign href       = w_in_line;
  assign p_valid    = tick && w_in_line;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = w_frame_end;
  // The high byte comes straight from the RAM, which holds it for the whole slot.
  assign p_data     = !w_in_line ? 8'h00 :
                      (w_hcnt[0] == BYTE_LO) ? r_lo : mem_data[15:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (w_frame_end || (r_state == S_IDLE)) begin
      r_addr <= '0;
    end else if (mem_rd) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lo <= 8'h00;
    end else if (tick && w_in_line && (w_hcnt[0] == BYTE_HI)) begin
      r_lo <= mem_data[7:0];
    end
  end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Scoreboard bench for dvp_frame_tx: a frame-level model queues the expected per-slot outputs,
// a negedge monitor compares the DUT against the slot at the head of the queue.
module tb_dvp_frame_tx;

  localparam int HA  = 4;
  localparam int VA  = 3;
  localparam int HB  = 2;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int AW  = 17;
  localparam int L   = 2 * HA + HB;
  localparam int F   = (VS + VBP + VA + VFP) * L;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [15:0]   mem_data = 16'h0000;
  logic          vsync;
  logic          href;
  logic [7:0]    p_data;
  logic          p_valid;
  logic          busy;
  logic          frame_done;

  typedef struct packed {
    logic          vs;
    logic          hr;
    logic [7:0]    pd;
    logic          rd;
    logic [AW-1:0] addr;
    logic          done;
  } slot_t;

  slot_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    tick_mode = 0;
  int    pv_cnt, rd_cnt, done_cnt, vs_ticks, ticks_since, done_at;

  dvp_frame_tx #(
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .V_BP        (VBP),
    .V_FP        (VFP),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .continuous (continuous),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .vsync      (vsync),
    .href       (href),
    .p_data     (p_data),
    .p_valid    (p_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Frame RAM: mem[n] = A000|n, one-clock read latency, data held between reads.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= 16'hA000 | 16'(mem_addr);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected slot stream of one whole frame, derived from line/pixel geometry.
  function automatic void push_frame();
    for (int s = 0; s < F; s++) begin
      slot_t e;
      int line, h, a, pix, nline, nh, na;
      logic [15:0] word;
      e = '0;
      line = s / L;
      h    = s % L;
      a    = line - VS - VBP;
      e.vs = (line < VS);
      e.hr = (a >= 0) && (a < VA) && (h < 2 * HA);
      if (e.hr) begin
        pix  = a * HA + h / 2;
        word = 16'hA000 | 16'(pix);
        e.pd = (h % 2 == 0) ? word[15:8] : word[7:0];
      end
      nline = (s + 1) / L;
      nh    = (s + 1) % L;
      na    = nline - VS - VBP;
      if ((s + 1 < F) && (na >= 0) && (na < VA) && (nh < 2 * HA) && (nh % 2 == 0)) begin
        e.rd   = 1'b1;
        e.addr = AW'(na * HA + nh / 2);
      end
      e.done = (s == F - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin : monitor
    slot_t cur;
    logic  was_busy;
    if (!rst) begin
      chk("rst_vsync", 32'(vsync), 32'd0);
      chk("rst_href", 32'(href), 32'd0);
      chk("rst_p_data", 32'(p_data), 32'd0);
      chk("rst_p_valid", 32'(p_valid), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      exp_q.delete();
    end else begin
      was_busy = (exp_q.size() != 0);
      cur = was_busy ? exp_q[0] : '0;
      chk("busy", 32'(busy), 32'(was_busy));
      chk("vsync", 32'(vsync), 32'(cur.vs));
      chk("href", 32'(href), 32'(cur.hr));
      chk("p_data", 32'(p_data), 32'(cur.pd));
      chk("p_valid", 32'(p_valid), 32'(tick & cur.hr));
      chk("mem_rd", 32'(mem_rd), 32'(tick & cur.rd));
      chk("frame_done", 32'(frame_done), 32'(tick & cur.done));
      if (tick && cur.rd) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
      if (!was_busy) chk("idle_mem_addr", 32'(mem_addr), 32'd0);
      if (tick && p_valid) pv_cnt++;
      if (mem_rd) rd_cnt++;
      if (tick && vsync) vs_ticks++;
      if (frame_done) begin
        done_cnt++;
        done_at = ticks_since;
      end
      if (tick) ticks_since++;
      if (tick && was_busy) begin
        void'(exp_q.pop_front());
        if (cur.done && continuous) push_frame();
      end
      if (start && !was_busy) push_frame();
    end
  end

  // Byte-slot enable: every clock, one in three, or random.
  always begin : tick_gen
    int phase;
    @(posedge clk);
    #1;
    case (tick_mode)
      0:       tick = 1'b1;
      1: begin
        tick  = (phase == 0);
        phase = (phase + 1) % 3;
      end
      default: tick = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic clr_cnt();
    pv_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    vs_ticks = 0;
    ticks_since = 0;
    done_at = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || busy) && (n < budget)) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with tick every clock.
    tick_mode = 0;
    clr_cnt();
    pulse_start();
    wait_idle(200);
    chk("f1_p_valid_count", pv_cnt, 24);
    chk("f1_mem_rd_count", rd_cnt, 12);
    chk("f1_vsync_ticks", vs_ticks, 10);
    chk("f1_frame_done_count", done_cnt, 1);
    chk("f1_frame_done_tick", done_at, 60);

    // Tick one clock in three.
    tick_mode = 1;
    clr_cnt();
    pulse_start();
    wait_idle(600);
    chk("slow_p_valid_count", pv_cnt, 24);
    chk("slow_mem_rd_count", rd_cnt, 12);
    chk("slow_frame_done_count", done_cnt, 1);

    // Continuous mode, cleared part way through frame 2.
    tick_mode = 0;
    continuous = 1'b1;
    clr_cnt();
    pulse_start();
    begin
      int n;
      n = 0;
      while ((done_cnt < 1) && (n < 300)) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("cont_first_done_seen", 32'(done_cnt >= 1), 32'd1);
    end
    repeat (25) @(posedge clk);
    #1;
    continuous = 1'b0;
    wait_idle(300);
    chk("cont_frame_done_count", done_cnt, 2);
    chk("cont_mem_rd_count", rd_cnt, 24);

    // Start while busy in the active region is ignored.
    clr_cnt();
    pulse_start();
    repeat (30) @(posedge clk);
    #1;
    pulse_start();
    wait_idle(200);
    chk("busy_start_done_count", done_cnt, 1);
    chk("busy_start_p_valid_count", pv_cnt, 24);

    // Start on the same clock as frame end with continuous=0.
    clr_cnt();
    pulse_start();
    repeat (59) @(posedge clk);
    #1;
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("coincident_start_busy", 32'(busy), 32'd0);
    chk("coincident_start_done_count", done_cnt, 1);

    // Asynchronous reset during active line 2, byte 5, then a clean frame.
    clr_cnt();
    pulse_start();
    repeat (45) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_no_frame_done", done_cnt, 0);
    clr_cnt();
    pulse_start();
    wait_idle(200);
    chk("post_reset_p_valid_count", pv_cnt, 24);
    chk("post_reset_mem_rd_count", rd_cnt, 12);
    chk("post_reset_done_count", done_cnt, 1);

    // Random tick pattern, random continuous and start pulses.
    tick_mode = 2;
    for (int i = 0; i < 8; i++) begin
      continuous = 1'($urandom_range(0, 1));
      pulse_start();
      repeat ($urandom_range(10, 200)) @(posedge clk);
      #1;
    end
    continuous = 1'b0;
    wait_idle(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
